// File: rtl/vector_op_engine_if.sv
// vector_op_engine_if: command, UART receive-byte and transmit-byte signals between the decoder/UART and the engine.
interface vector_op_engine_if;
  logic [7:0] op, rx_data, tx_data;
  logic rx_valid, tx_ready, tx_valid, op_finished, busy;
  modport master(output op, rx_data, rx_valid, tx_ready, input tx_data, tx_valid, op_finished, busy);
  modport slave(input op, rx_data, rx_valid, tx_ready, output tx_data, tx_valid, op_finished, busy);
endinterface

// File: rtl/vector_op_engine.sv
// vector_op_engine: holds vectors A/B, runs write/read/sum/avg/manhattan commands, streams result bytes over valid/ready.
module vector_op_engine #(
  parameter int N_ELEMS = 4,
  parameter int ELEM_W = 8
) (
  input logic clk,
  input logic rst_n,
  vector_op_engine_if.slave bus
);
  localparam int EW = $clog2(N_ELEMS);
  localparam int IW = EW + 2;
  localparam logic [7:0] OP_WA = 8'd97, OP_WB = 8'd98, OP_RA = 8'd99, OP_RB = 8'd100;
  localparam logic [7:0] OP_SUM = 8'd101, OP_AVG = 8'd102, OP_MAN = 8'd103;
  typedef enum logic [2:0] {IDLE, LOAD, CALC, SEND, DONE, WAIT_CLR} state_t;
  state_t st, nxt;
  logic [7:0] cmd;
  logic [IW-1:0] idx, total;
  logic [15:0] acc;
  logic [ELEM_W-1:0] a [N_ELEMS];
  logic [ELEM_W-1:0] b [N_ELEMS];
  logic [EW-1:0] el;
  logic [8:0] sum;
  logic signed [8:0] diff;
  logic [7:0] mag;
  logic last;
  // sumVec sends two bytes per element, so its element index is idx/2
  assign el = cmd == OP_SUM ? idx[EW:1] : idx[EW-1:0];
  assign sum = {1'b0, a[el]} + {1'b0, b[el]};
  assign diff = $signed({1'b0, a[el]}) - $signed({1'b0, b[el]});
  assign mag = diff[8] ? 8'(-diff) : diff[7:0];
  assign total = cmd == OP_SUM ? IW'(2 * N_ELEMS) : cmd == OP_MAN ? IW'(2) : IW'(N_ELEMS);
  assign last = idx == total - IW'(1);
  assign bus.tx_valid = st == SEND;
  assign bus.op_finished = st == DONE;
  assign bus.busy = st != IDLE;
  assign bus.tx_data = st != SEND ? 8'd0 :
    cmd == OP_RA ? a[el] : cmd == OP_RB ? b[el] : cmd == OP_AVG ? sum[8:1] :
    cmd == OP_SUM ? (idx[0] ? sum[7:0] : {7'd0, sum[8]}) : idx[0] ? acc[7:0] : acc[15:8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE: if (bus.op != 8'd0)
        nxt = (bus.op == OP_WA || bus.op == OP_WB) ? LOAD :
              (bus.op >= OP_RA && bus.op <= OP_AVG) ? SEND : bus.op == OP_MAN ? CALC : DONE;
      LOAD: if (bus.rx_valid && idx == IW'(N_ELEMS - 1)) nxt = DONE;
      CALC: if (idx == IW'(N_ELEMS - 1)) nxt = SEND;
      SEND: if (bus.tx_ready && last) nxt = DONE;
      DONE: nxt = WAIT_CLR;
      WAIT_CLR: if (bus.op == 8'd0) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd <= '0;
      idx <= '0;
      acc <= '0;
      for (int i = 0; i < N_ELEMS; i++) begin
        a[i] <= '0;
        b[i] <= '0;
      end
    end else case (st)
      IDLE: if (bus.op != 8'd0) begin
        cmd <= bus.op;
        idx <= '0;
        acc <= '0;
      end
      LOAD: if (bus.rx_valid) begin
        if (cmd == OP_WA) a[el] <= bus.rx_data;
        else b[el] <= bus.rx_data;
        idx <= idx + IW'(1);
      end
      CALC: begin
        acc <= acc + 16'(mag);
        idx <= idx == IW'(N_ELEMS - 1) ? '0 : idx + IW'(1);
      end
      SEND: if (bus.tx_ready) idx <= idx + IW'(1);
      default: ;
    endcase
endmodule

// File: tb/tb_vector_op_engine.sv
// tb_vector_op_engine: table vectors, hand-written corner sequences and random commands against a vector-level model.
module tb_vector_op_engine;
  localparam int N = 4;
  typedef struct packed {
    logic [7:0] c;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] e;
    logic [3:0] n;
  } vec_t;
  logic clk = 0, rst_n = 0;
  int checks = 0, errors = 0;
  int fins, hold_err;
  logic pv;
  logic [7:0] pd;
  logic [7:0] got[$], exp_q[$];
  int ma[N], mb[N];
  vec_t tv[6];
  vector_op_engine_if bus();
  vector_op_engine #(.N_ELEMS(N), .ELEM_W(8)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic step(input logic rv, input logic [7:0] rd, input logic tr);
    bus.rx_valid = rv;
    bus.rx_data = rd;
    bus.tx_ready = tr;
    @(negedge clk);
    if (bus.tx_valid) begin
      if (pv && bus.tx_data !== pd) hold_err++;
      if (tr) got.push_back(bus.tx_data);
    end
    pv = bus.tx_valid && !tr;
    pd = bus.tx_data;
    if (bus.op_finished) fins++;
    @(posedge clk);
    #1;
  endtask
  task automatic begin_cmd(input logic [7:0] c);
    bus.op = c;
    got.delete();
    fins = 0;
    hold_err = 0;
    pv = 0;
    step(0, 0, 0);
  endtask
  task automatic end_cmd();
    bus.op = 0;
    step(0, 0, 0);
    step(0, 0, 0);
    check("busy_after_clear", bus.busy, 0);
  endtask
  function automatic void model(input int c);
    int s, m;
    exp_q.delete();
    m = 0;
    for (int i = 0; i < N; i++) begin
      s = ma[i] + mb[i];
      if (c == 99) exp_q.push_back(8'(ma[i]));
      if (c == 100) exp_q.push_back(8'(mb[i]));
      if (c == 101) begin
        exp_q.push_back(8'(s / 256));
        exp_q.push_back(8'(s % 256));
      end
      if (c == 102) exp_q.push_back(8'(s / 2));
      m += ma[i] > mb[i] ? ma[i] - mb[i] : mb[i] - ma[i];
    end
    if (c == 103) begin
      exp_q.push_back(8'(m / 256));
      exp_q.push_back(8'(m % 256));
    end
  endfunction
  task automatic cmp_stream(input string n);
    check({n, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) check(n, got[i], exp_q[i]);
  endtask
  task automatic load(input logic [7:0] c, input logic [31:0] v, input int gmax);
    begin_cmd(c);
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, gmax)) step(0, 8'($urandom), 0);
      step(1, v[31-8*i -: 8], 0);
      if (c == 97) ma[i] = int'(v[31-8*i -: 8]);
      else mb[i] = int'(v[31-8*i -: 8]);
    end
    repeat (3) step(0, 0, 0);
    check("load_finish", fins, 1);
    check("load_no_tx", got.size(), 0);
    end_cmd();
  endtask
  task automatic run(input logic [7:0] c, input int rm, input int hold, input logic noise);
    begin_cmd(c);
    for (int k = 0; k < 200 && fins == 0; k++)
      step(noise && $urandom_range(0, 3) == 0, 8'($urandom),
           rm == 0 ? 1'b1 : rm == 1 ? 1'(k % 2) : 1'($urandom_range(0, 1)));
    repeat (hold) step(noise, 8'($urandom), 1'b1);
    check("finish_once", fins, 1);
    check("tx_held", hold_err, 0);
    end_cmd();
    model(c);
    cmp_stream("stream");
  endtask
  initial begin
    tv[0] = '{8'd101, {8'd1, 8'd2, 8'd3, 8'd4}, {8'd10, 8'd20, 8'd30, 8'd40},
              {8'd0, 8'd11, 8'd0, 8'd22, 8'd0, 8'd33, 8'd0, 8'd44}, 4'd8};
    tv[1] = '{8'd102, {8'd255, 8'd1, 8'd200, 8'd7}, {8'd255, 8'd2, 8'd100, 8'd9},
              {8'd255, 8'd1, 8'd150, 8'd8, 32'd0}, 4'd4};
    tv[2] = '{8'd101, {8'd255, 8'd1, 8'd200, 8'd7}, {8'd255, 8'd2, 8'd100, 8'd9},
              {8'd1, 8'd254, 8'd0, 8'd3, 8'd1, 8'd44, 8'd0, 8'd16}, 4'd8};
    tv[3] = '{8'd103, {8'd255, 8'd1, 8'd200, 8'd7}, {8'd255, 8'd2, 8'd100, 8'd9},
              {8'd0, 8'd103, 48'd0}, 4'd2};
    tv[4] = '{8'd99, {8'd255, 8'd1, 8'd200, 8'd7}, {8'd255, 8'd2, 8'd100, 8'd9},
              {8'd255, 8'd1, 8'd200, 8'd7, 32'd0}, 4'd4};
    tv[5] = '{8'd100, {8'd255, 8'd1, 8'd200, 8'd7}, {8'd255, 8'd2, 8'd100, 8'd9},
              {8'd255, 8'd2, 8'd100, 8'd9, 32'd0}, 4'd4};
    bus.op = 0;
    bus.rx_valid = 0;
    bus.rx_data = 0;
    bus.tx_ready = 0;
    for (int i = 0; i < N; i++) begin
      ma[i] = 0;
      mb[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_finished", bus.op_finished, 0);
    rst_n = 1;
    load(8'd97, {8'd1, 8'd2, 8'd3, 8'd4}, 3);
    run(8'd99, 0, 0, 0);
    foreach (tv[i]) begin
      load(8'd97, tv[i].a, 2);
      load(8'd98, tv[i].b, 2);
      run(tv[i].c, i % 3, 2, 0);
      exp_q.delete();
      for (int j = 0; j < int'(tv[i].n); j++) exp_q.push_back(tv[i].e[63-8*j -: 8]);
      cmp_stream("table");
    end
    run(8'd103, 1, 0, 1);
    run(8'd99, 0, 6, 1);
    run(8'd50, 0, 3, 1);
    run(8'd99, 2, 0, 0);
    run(8'd100, 2, 0, 0);
    begin_cmd(8'd97);
    step(1, 8'd9, 0);
    step(1, 8'd8, 0);
    rst_n = 0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_tx_valid", bus.tx_valid, 0);
    check("midrst_finished", bus.op_finished, 0);
    bus.op = 0;
    step(0, 0, 0);
    step(0, 0, 0);
    check("midrst_no_finish", fins, 0);
    rst_n = 1;
    for (int i = 0; i < N; i++) begin
      ma[i] = 0;
      mb[i] = 0;
    end
    run(8'd99, 0, 0, 0);
    load(8'd97, {8'd5, 8'd6, 8'd7, 8'd8}, 1);
    run(8'd99, 0, 0, 0);
    for (int r = 0; r < 30; r++) begin
      int s;
      s = $urandom_range(0, 8);
      if (s == 0) load(8'd97, $urandom, 3);
      else if (s == 1) load(8'd98, $urandom, 3);
      else if (s == 7) run($urandom_range(0, 1) ? 8'($urandom_range(1, 96)) : 8'($urandom_range(104, 255)), 0, 1, 1);
      else run(8'(97 + s), $urandom_range(0, 2), $urandom_range(0, 3), 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_op_engine.md
Name: vector_op_engine

Overview:
- Datapath/executor stage directly downstream of the command decoder.
- Consumes the decoder's 8-bit `op` code and the UART receive byte stream.
- Holds vectors A and B, executes write/read/sum/average/Manhattan-distance commands, and streams results to the UART transmitter through a valid/ready handshake.
- Pulses `op_finished` back to the decoder so the decoder can return to idle and accept the next command.

Parameters:
- N_ELEMS, 4, number of elements per vector (2..16).
- ELEM_W, 8, element width in bits; fixed at 8 so every element is one UART byte.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  8  command code from decoder: 0 idle, 97 writeVec_A, 98 writeVec_B, 99 readVec_A, 100 readVec_B, 101 sumVec, 102 avgVec, 103 manDist.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe; `rx_data` is valid this cycle.
- tx_ready  in  1  transmitter can accept a byte this cycle.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  `tx_data` is valid; a transfer occurs when `tx_valid && tx_ready`.
- op_finished  out  1  one-cycle pulse when the command completes.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State forced to IDLE; index and accumulator cleared.
  - All A/B elements cleared to 0.
  - `tx_valid`, `tx_data`, `op_finished` and `busy` all 0.
  - Reset mid-command abandons the command; no `op_finished` is issued.
- States: IDLE, LOAD, CALC, SEND, DONE, WAIT_CLR.
- IDLE: on `op != 0`, latch `op` into `cmd`, clear index `idx` and accumulator `acc`, then:
  - 97/98 -> LOAD.
  - 99..102 -> SEND.
  - 103 -> CALC.
  - Any other nonzero code -> DONE with no side effects.
- LOAD:
  - Each `rx_valid` writes `rx_data` to A[idx] (97) or B[idx] (98) and increments `idx`.
  - On the write of element N_ELEMS-1 -> DONE.
  - The command byte itself was consumed by the decoder before `op` went nonzero, so it is never stored.
- CALC (manDist):
  - One element per cycle: `acc += |A[idx]-B[idx]|`, with the subtraction done in 9-bit signed arithmetic.
  - `acc` is 16 bits and cannot overflow for N_ELEMS ≤ 16.
  - After N_ELEMS cycles -> SEND.
- SEND: `tx_valid` stays high with stable `tx_data` until accepted; `idx` advances only on a transfer.
  - 99: A[0..N-1], N bytes.
  - 100: B[0..N-1], N bytes.
  - 101: per element, 9-bit sum A[i]+B[i] sent as 2 bytes, MSB byte ({7'b0,carry}) then LSB byte; 2N bytes total.
  - 102: per element, (A[i]+B[i])>>1, truncated, computed from the 9-bit sum; N bytes.
  - 103: `acc`, MSB byte then LSB byte; 2 bytes.
  - After the last transfer, `tx_valid` drops in the next cycle -> DONE.
- DONE: `op_finished`=1 for exactly one cycle -> WAIT_CLR.
- WAIT_CLR: hold until `op == 0`, then -> IDLE. This prevents re-execution of a stale `op`.
- Ignored inputs:
  - `rx_valid` is ignored outside LOAD.
  - `tx_ready` is ignored while `tx_valid`=0.
- Vector contents persist across commands until overwritten or reset.
- Latency: readVec with `tx_ready` held high gives first byte valid 1 cycle after leaving IDLE, and one byte per cycle after that.

Test Plan:
- Reset, then op=97 and rx bytes 1,2,3,4 with gaps -> A={1,2,3,4}; one `op_finished` pulse after the 4th strobe; `busy` returns to 0 once op=0.
- Load A={1,2,3,4}, B={10,20,30,40}; op=101 with `tx_ready`=1 -> tx stream 0,11,0,22,0,33,0,44.
- A={255,1,200,7}, B={255,2,100,9}; op=102 -> tx 255,1,150,8; op=101 first pair -> 1,254 (sum 510).
- Same A/B; op=103 -> |0|+|-1|+|100|+|-2| = 103, tx 0,103; `tx_ready` toggled 1/0 each cycle -> identical bytes, each held until accepted.
- op=99 held nonzero after `op_finished` -> only one stream of 4 bytes is sent (WAIT_CLR holds); op=50 -> immediate `op_finished`, A/B unchanged, no tx.
- rst_n asserted after 2 of 4 LOAD bytes -> all outputs 0 immediately and A cleared; a subsequent full op=97 load completes normally.
